// File: rtl/alu_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the ALU command sequencer: default sizing, ALU
// opcode and operand-select encodings, the sequencer state type, and the
// helper that masks the ALU carry down to the operations where it means
// something.
// ---------------------------------------------------------------------------
package alu_seq_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int NREGS_DEF = 4;

  // ALU operation codes (driven on the ALU ctrl_op input)
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;
  localparam logic [2:0] OP_ROR = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  // Operand select for shift/rotate ops (ALU ctrl_in)
  localparam logic CTRL_SEL_A = 1'b0;
  localparam logic CTRL_SEL_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    RESP  = 2'b10
  } state_t;

  // Only ADD produces a carry the host may rely on; whatever the ALU
  // drives on carry_bit for other operations is forced to zero.
  function automatic logic mask_carry(input logic [2:0] op, input logic carry);
    return (op == OP_ADD) ? carry : 1'b0;
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// ---------------------------------------------------------------------------
// alu_seq_regfile
// NREGS x WIDTH register file with two combinational read ports and one
// synchronous write port. All entries clear asynchronously on rst.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   we, waddr, wdata   write port (takes effect on the rising edge)
//   raddr_a, rdata_a   read port A (combinational)
//   raddr_b, rdata_b   read port B (combinational)
// ---------------------------------------------------------------------------
module alu_seq_regfile
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREGS = NREGS_DEF,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] regs_r [NREGS];

  // Storage: clear on reset, single write per cycle otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= {WIDTH{1'b0}};
      end
    end else if (we) begin
      regs_r[waddr] <= wdata;
    end
  end

  assign rdata_a = regs_r[raddr_a];
  assign rdata_b = regs_r[raddr_b];

endmodule

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
// Command-side driver for the 8-bit combinational ALU. Accepts load-immediate
// or ALU commands on a valid/ready channel, drives registered operands from
// an internal register file, writes the result (or immediate) back to rd and
// returns it on a valid/ready response channel. One command in flight.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   cmd_valid / cmd_ready          command handshake
//   cmd_ld                         1 = load immediate, 0 = ALU op
//   cmd_op, cmd_in                 ALU opcode / shift operand select
//   cmd_imm                        load value
//   cmd_ra, cmd_rb, cmd_rd         source A, source B, destination
//   alu_a, alu_b, alu_op,
//   alu_ctrl_in                    registered drive into the ALU
//   alu_result, alu_carry          ALU outputs
//   rsp_valid / rsp_ready          response handshake
//   rsp_data, rsp_carry            value written to rd and its carry
//   busy                           high whenever not IDLE
// ---------------------------------------------------------------------------
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREGS = NREGS_DEF,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_ld,
  input  logic [2:0]       cmd_op,
  input  logic             cmd_in,
  input  logic [WIDTH-1:0] cmd_imm,
  input  logic [AW-1:0]    cmd_ra,
  input  logic [AW-1:0]    cmd_rb,
  input  logic [AW-1:0]    cmd_rd,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  output logic             alu_ctrl_in,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_carry,
  output logic             busy
);

  state_t           state_r;
  logic [AW-1:0]    rd_r;
  logic             accept_s;
  logic             rf_we_s;
  logic [AW-1:0]    rf_waddr_s;
  logic [WIDTH-1:0] rf_wdata_s;
  logic [WIDTH-1:0] rf_rdata_a_s;
  logic [WIDTH-1:0] rf_rdata_b_s;

  // Ready is suppressed while rst is high so nothing is accepted during reset.
  assign cmd_ready = (state_r == IDLE) && !rst;
  assign accept_s  = cmd_valid && cmd_ready;

  alu_seq_regfile #(
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (rf_we_s),
    .waddr   (rf_waddr_s),
    .wdata   (rf_wdata_s),
    .raddr_a (cmd_ra),
    .rdata_a (rf_rdata_a_s),
    .raddr_b (cmd_rb),
    .rdata_b (rf_rdata_b_s)
  );

  // Register-file write port: immediate on an accepted load, ALU result in ISSUE
  always_comb begin
    rf_we_s    = 1'b0;
    rf_waddr_s = rd_r;
    rf_wdata_s = alu_result;
    case (state_r)
      IDLE: begin
        if (accept_s && cmd_ld) begin
          rf_we_s    = 1'b1;
          rf_waddr_s = cmd_rd;
          rf_wdata_s = cmd_imm;
        end else begin
          rf_we_s    = 1'b0;
        end
      end
      ISSUE: begin
        rf_we_s    = 1'b1;
        rf_waddr_s = rd_r;
        rf_wdata_s = alu_result;
      end
      default: begin
        rf_we_s    = 1'b0;
      end
    endcase
  end

  // Sequencer FSM with registered ALU drive and response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      rd_r        <= {AW{1'b0}};
      alu_a       <= {WIDTH{1'b0}};
      alu_b       <= {WIDTH{1'b0}};
      alu_op      <= 3'b000;
      alu_ctrl_in <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= {WIDTH{1'b0}};
      rsp_carry   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            busy <= 1'b1;
            if (cmd_ld) begin
              rsp_data  <= cmd_imm;
              rsp_carry <= 1'b0;
              rsp_valid <= 1'b1;
              state_r   <= RESP;
            end else begin
              // Sources are sampled here, so rd aliasing ra/rb sees old data.
              alu_a       <= rf_rdata_a_s;
              alu_b       <= rf_rdata_b_s;
              alu_op      <= cmd_op;
              alu_ctrl_in <= cmd_in;
              rd_r        <= cmd_rd;
              state_r     <= ISSUE;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          // The ALU is combinational and has settled within this cycle.
          rsp_data  <= alu_result;
          rsp_carry <= mask_carry(alu_op, alu_carry);
          rsp_valid <= 1'b1;
          state_r   <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state_r   <= IDLE;
          end else begin
            state_r   <= RESP;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
// Self-checking bench: alu_sequencer wired back-to-back with a behavioural
// model of the 8-bit ALU. Expected responses are queued when a command is
// accepted and compared when the sequencer presents its response.
// ---------------------------------------------------------------------------
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_ld, cmd_in;
  logic [2:0] cmd_op;
  logic [7:0] cmd_imm;
  logic [1:0] cmd_ra, cmd_rb, cmd_rd;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_op;
  logic       alu_ctrl_in, alu_carry;
  logic       rsp_valid, rsp_ready, rsp_carry, busy;
  logic [7:0] rsp_data;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       carry;
  } exp_t;

  typedef struct packed {
    logic       ld;
    logic [2:0] op;
    logic       in;
    logic [7:0] imm;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [1:0] rd;
    logic [7:0] ed;
    logic       ec;
    int         lat;
  } cmd_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  alu_sequencer #(.WIDTH(8), .NREGS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_ld      (cmd_ld),
    .cmd_op      (cmd_op),
    .cmd_in      (cmd_in),
    .cmd_imm     (cmd_imm),
    .cmd_ra      (cmd_ra),
    .cmd_rb      (cmd_rb),
    .cmd_rd      (cmd_rd),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_ctrl_in (alu_ctrl_in),
    .alu_result  (alu_result),
    .alu_carry   (alu_carry),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_carry   (rsp_carry),
    .busy        (busy)
  );

  // Behavioural ALU. Carry for non-ADD ops is deliberately non-zero where
  // natural (borrow, bit shifted out) so the sequencer's masking matters.
  logic [7:0] alu_sel;
  logic [8:0] alu_wide;
  always_comb begin
    alu_sel  = (alu_ctrl_in == CTRL_SEL_B) ? alu_b : alu_a;
    alu_wide = 9'h000;
    case (alu_op)
      OP_ADD:  alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
      OP_SUB:  alu_wide = {1'b0, alu_a} - {1'b0, alu_b};
      OP_AND:  alu_wide = {1'b0, alu_a & alu_b};
      OP_OR:   alu_wide = {1'b0, alu_a | alu_b};
      OP_ROL:  alu_wide = {alu_sel[7], alu_sel[6:0], alu_sel[7]};
      OP_ROR:  alu_wide = {alu_sel[0], alu_sel[0], alu_sel[7:1]};
      OP_SHL:  alu_wide = {alu_sel[7], alu_sel[6:0], 1'b0};
      OP_SHR:  alu_wide = {alu_sel[0], 1'b0, alu_sel[7:1]};
      default: alu_wide = 9'h000;
    endcase
  end
  assign alu_result = alu_wide[7:0];
  assign alu_carry  = alu_wide[8];

  // Present a command and wait (bounded) for it to be accepted.
  task automatic send(input cmd_t c, input bit hold, input bit push,
                      output int acc, output bit ok);
    cmd_ld    = c.ld;
    cmd_op    = c.op;
    cmd_in    = c.in;
    cmd_imm   = c.imm;
    cmd_ra    = c.ra;
    cmd_rb    = c.rb;
    cmd_rd    = c.rd;
    cmd_valid = 1'b1;
    ok  = 1'b0;
    acc = -1;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (ok) begin
      acc = cyc;
      if (push) exp_q.push_back({c.ed, c.ec});
      @(posedge clk); #1;
    end
    if (!hold || !ok) cmd_valid = 1'b0;
  endtask

  // Wait (bounded) for rsp_valid; does not consume the handshake edge.
  task automatic wait_rsp(output logic [7:0] d, output logic cr,
                          output int at, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    d  = rsp_data;
    cr = rsp_carry;
    at = cyc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({cmd_ready, rsp_valid, busy, rsp_carry, rsp_data, alu_a, alu_b, alu_op, alu_ctrl_in} !== 32'h0) begin
      failures++;
      $display("FAIL reset_state got rdy=%b vld=%b busy=%b data=%h a=%h b=%h op=%b, expected all zero",
               cmd_ready, rsp_valid, busy, rsp_data, alu_a, alu_b, alu_op);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, busy} !== 2'b10) begin
      failures++;
      $display("FAIL reset_release got rdy=%b busy=%b expected rdy=1 busy=0", cmd_ready, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add_sub();
    cmd_t tbl[5];
    exp_t e;
    logic [7:0] d;
    logic cr;
    int acc, at;
    bit ok_s, ok_r;
    tbl[0] = '{1'b1, OP_ADD, CTRL_SEL_A, 8'hC8, 2'd0, 2'd0, 2'd0, 8'hC8, 1'b0, 1};
    tbl[1] = '{1'b1, OP_ADD, CTRL_SEL_A, 8'h64, 2'd0, 2'd0, 2'd1, 8'h64, 1'b0, 1};
    tbl[2] = '{1'b0, OP_ADD, CTRL_SEL_A, 8'h00, 2'd0, 2'd1, 2'd2, 8'h2C, 1'b1, 2};
    tbl[3] = '{1'b0, OP_SUB, CTRL_SEL_A, 8'h00, 2'd1, 2'd0, 2'd3, 8'h9C, 1'b0, 2};
    tbl[4] = '{1'b0, OP_ADD, CTRL_SEL_A, 8'h00, 2'd3, 2'd3, 2'd3, 8'h38, 1'b1, 2};
    rsp_ready = 1'b1;
    foreach (tbl[i]) begin
      send(tbl[i], 1'b0, 1'b1, acc, ok_s);
      wait_rsp(d, cr, at, ok_r);
      if (ok_s) e = exp_q.pop_front();
      checks++;
      if (!ok_s || !ok_r) begin
        failures++;
        $display("FAIL add_sub[%0d] timeout accepted=%b responded=%b expected both 1", i, ok_s, ok_r);
      end else begin
        if ({d, cr} !== {e.data, e.carry}) begin
          failures++;
          $display("FAIL add_sub[%0d] got data=%h carry=%b expected data=%h carry=%b", i, d, cr, e.data, e.carry);
        end
        checks++;
        if (at - acc != tbl[i].lat) begin
          failures++;
          $display("FAIL add_sub_latency[%0d] got %0d expected %0d", i, at - acc, tbl[i].lat);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_shifts();
    cmd_t tbl[6];
    exp_t e;
    logic [7:0] d;
    logic cr;
    int acc, at;
    bit ok_s, ok_r;
    tbl[0] = '{1'b1, OP_ADD, CTRL_SEL_A, 8'h81, 2'd0, 2'd0, 2'd0, 8'h81, 1'b0, 1};
    tbl[1] = '{1'b0, OP_ROL, CTRL_SEL_A, 8'h00, 2'd0, 2'd1, 2'd2, 8'h03, 1'b0, 2};
    tbl[2] = '{1'b0, OP_ROR, CTRL_SEL_A, 8'h00, 2'd0, 2'd1, 2'd2, 8'hC0, 1'b0, 2};
    tbl[3] = '{1'b0, OP_SHR, CTRL_SEL_A, 8'h00, 2'd0, 2'd1, 2'd2, 8'h40, 1'b0, 2};
    tbl[4] = '{1'b0, OP_SHL, CTRL_SEL_A, 8'h00, 2'd0, 2'd1, 2'd2, 8'h02, 1'b0, 2};
    tbl[5] = '{1'b0, OP_ROL, CTRL_SEL_B, 8'h00, 2'd0, 2'd1, 2'd2, 8'hC8, 1'b0, 2};
    rsp_ready = 1'b1;
    foreach (tbl[i]) begin
      send(tbl[i], 1'b0, 1'b1, acc, ok_s);
      wait_rsp(d, cr, at, ok_r);
      if (ok_s) e = exp_q.pop_front();
      checks++;
      if (!ok_s || !ok_r) begin
        failures++;
        $display("FAIL shifts[%0d] timeout accepted=%b responded=%b expected both 1", i, ok_s, ok_r);
      end else if ({d, cr} !== {e.data, e.carry}) begin
        failures++;
        $display("FAIL shifts[%0d] got data=%h carry=%b expected data=%h carry=%b", i, d, cr, e.data, e.carry);
      end
      @(posedge clk); #1;
    end
    // ALU drive keeps the last issued operands once back in IDLE
    checks++;
    if ({alu_a, alu_b, alu_op, alu_ctrl_in} !== {8'h81, 8'h64, OP_ROL, CTRL_SEL_B}) begin
      failures++;
      $display("FAIL alu_hold got a=%h b=%h op=%b in=%b expected a=81 b=64 op=100 in=1",
               alu_a, alu_b, alu_op, alu_ctrl_in);
    end
  endtask

  task automatic test_backpressure();
    cmd_t c_or, c_ld, c_chk;
    exp_t e;
    logic [7:0] d;
    logic cr;
    int acc, at;
    bit ok_s, ok_r;
    c_or  = '{1'b0, OP_OR, CTRL_SEL_A, 8'h00, 2'd0, 2'd1, 2'd2, 8'hE5, 1'b0, 2};
    c_ld  = '{1'b1, OP_ADD, CTRL_SEL_A, 8'hFF, 2'd0, 2'd0, 2'd1, 8'hFF, 1'b0, 1};
    c_chk = '{1'b0, OP_OR, CTRL_SEL_A, 8'h00, 2'd1, 2'd1, 2'd2, 8'h64, 1'b0, 2};
    rsp_ready = 1'b0;
    send(c_or, 1'b0, 1'b1, acc, ok_s);
    wait_rsp(d, cr, at, ok_r);
    if (ok_s) e = exp_q.pop_front();
    checks++;
    if (!ok_s || !ok_r) begin
      failures++;
      $display("FAIL backpressure timeout accepted=%b responded=%b expected both 1", ok_s, ok_r);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if ({rsp_valid, rsp_data, rsp_carry, cmd_ready, busy} !== {1'b1, e.data, e.carry, 1'b0, 1'b1}) begin
          failures++;
          $display("FAIL backpressure_hold[%0d] got vld=%b data=%h carry=%b rdy=%b busy=%b expected vld=1 data=%h carry=%b rdy=0 busy=1",
                   k, rsp_valid, rsp_data, rsp_carry, cmd_ready, busy, e.data, e.carry);
        end
        if (k == 1) begin
          cmd_ld = c_ld.ld; cmd_imm = c_ld.imm; cmd_rd = c_ld.rd; cmd_valid = 1'b1;
        end else begin
          cmd_valid = 1'b0;
        end
        @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({rsp_valid, cmd_ready} !== 2'b01) begin
        failures++;
        $display("FAIL backpressure_release got vld=%b rdy=%b expected vld=0 rdy=1", rsp_valid, cmd_ready);
      end
    end
    // R1 must still hold 0x64: the pulsed load was not consumed
    send(c_chk, 1'b0, 1'b1, acc, ok_s);
    wait_rsp(d, cr, at, ok_r);
    if (ok_s) e = exp_q.pop_front();
    checks++;
    if (!ok_s || !ok_r || {d, cr} !== {e.data, e.carry}) begin
      failures++;
      $display("FAIL ignored_cmd got data=%h ok=%b%b expected data=%h", d, ok_s, ok_r, e.data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_issue();
    cmd_t c_ld, c_add, c_r2, c_r01;
    exp_t e;
    logic [7:0] d;
    logic cr;
    int acc, at;
    bit ok_s, ok_r, seen;
    c_ld  = '{1'b1, OP_ADD, CTRL_SEL_A, 8'h55, 2'd0, 2'd0, 2'd2, 8'h55, 1'b0, 1};
    c_add = '{1'b0, OP_ADD, CTRL_SEL_A, 8'h00, 2'd0, 2'd1, 2'd2, 8'hE5, 1'b0, 2};
    c_r2  = '{1'b0, OP_OR,  CTRL_SEL_A, 8'h00, 2'd2, 2'd2, 2'd3, 8'h00, 1'b0, 2};
    c_r01 = '{1'b0, OP_OR,  CTRL_SEL_A, 8'h00, 2'd0, 2'd1, 2'd3, 8'h00, 1'b0, 2};
    rsp_ready = 1'b1;
    send(c_ld, 1'b0, 1'b1, acc, ok_s);
    wait_rsp(d, cr, at, ok_r);
    if (ok_s) e = exp_q.pop_front();
    checks++;
    if (!ok_s || !ok_r || {d, cr} !== {e.data, e.carry}) begin
      failures++;
      $display("FAIL pre_reset_load got data=%h ok=%b%b expected data=%h", d, ok_s, ok_r, e.data);
    end
    @(posedge clk); #1;
    send(c_add, 1'b0, 1'b0, acc, ok_s);
    // Now in ISSUE: reset asynchronously
    rst = 1'b1;
    #1;
    checks++;
    if (!ok_s || {rsp_valid, busy, cmd_ready, rsp_data, rsp_carry, alu_a, alu_b} !== 28'h0) begin
      failures++;
      $display("FAIL reset_mid_issue got ok=%b vld=%b busy=%b rdy=%b data=%h a=%h b=%h expected all zero",
               ok_s, rsp_valid, busy, cmd_ready, rsp_data, alu_a, alu_b);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset got %b expected 1", cmd_ready);
    end
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (rsp_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL discarded_cmd got rsp_valid=1 after reset expected 0");
    end
    send(c_r2, 1'b0, 1'b1, acc, ok_s);
    wait_rsp(d, cr, at, ok_r);
    if (ok_s) e = exp_q.pop_front();
    checks++;
    if (!ok_s || !ok_r || {d, cr} !== {e.data, e.carry}) begin
      failures++;
      $display("FAIL r2_cleared got data=%h ok=%b%b expected data=%h", d, ok_s, ok_r, e.data);
    end
    @(posedge clk); #1;
    send(c_r01, 1'b0, 1'b1, acc, ok_s);
    wait_rsp(d, cr, at, ok_r);
    if (ok_s) e = exp_q.pop_front();
    checks++;
    if (!ok_s || !ok_r || {d, cr} !== {e.data, e.carry}) begin
      failures++;
      $display("FAIL r0_r1_cleared got data=%h ok=%b%b expected data=%h", d, ok_s, ok_r, e.data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    cmd_t ld[2];
    cmd_t tbl[5];
    int acc_arr[5];
    bit ok_arr[5];
    exp_t e;
    logic [7:0] d;
    logic cr;
    int acc, at, got;
    bit ok_s, ok_r;
    ld[0]  = '{1'b1, OP_ADD, CTRL_SEL_A, 8'h3A, 2'd0, 2'd0, 2'd0, 8'h3A, 1'b0, 1};
    ld[1]  = '{1'b1, OP_ADD, CTRL_SEL_A, 8'hC5, 2'd0, 2'd0, 2'd1, 8'hC5, 1'b0, 1};
    tbl[0] = '{1'b0, OP_ADD, CTRL_SEL_A, 8'h00, 2'd0, 2'd1, 2'd2, 8'hFF, 1'b0, 2};
    tbl[1] = '{1'b0, OP_SUB, CTRL_SEL_A, 8'h00, 2'd1, 2'd0, 2'd3, 8'h8B, 1'b0, 2};
    tbl[2] = '{1'b0, OP_AND, CTRL_SEL_A, 8'h00, 2'd0, 2'd1, 2'd2, 8'h00, 1'b0, 2};
    tbl[3] = '{1'b0, OP_OR,  CTRL_SEL_A, 8'h00, 2'd0, 2'd1, 2'd3, 8'hFF, 1'b0, 2};
    tbl[4] = '{1'b0, OP_SHL, CTRL_SEL_B, 8'h00, 2'd0, 2'd1, 2'd2, 8'h8A, 1'b0, 2};
    rsp_ready = 1'b1;
    foreach (ld[i]) begin
      send(ld[i], 1'b0, 1'b1, acc, ok_s);
      wait_rsp(d, cr, at, ok_r);
      if (ok_s) e = exp_q.pop_front();
      checks++;
      if (!ok_s || !ok_r || {d, cr} !== {e.data, e.carry}) begin
        failures++;
        $display("FAIL b2b_load[%0d] got data=%h ok=%b%b expected data=%h", i, d, ok_s, ok_r, e.data);
      end
      @(posedge clk); #1;
    end
    got = 0;
    fork
      begin
        for (int i = 0; i < 5; i++) send(tbl[i], 1'b1, 1'b1, acc_arr[i], ok_arr[i]);
        cmd_valid = 1'b0;
      end
      begin
        for (int j = 0; j < 5; j++) begin
          wait_rsp(d, cr, at, ok_r);
          checks++;
          if (!ok_r || exp_q.size() == 0) begin
            failures++;
            $display("FAIL b2b_rsp[%0d] timeout responded=%b queued=%0d expected a response", j, ok_r, exp_q.size());
            break;
          end
          e = exp_q.pop_front();
          if ({d, cr} !== {e.data, e.carry}) begin
            failures++;
            $display("FAIL b2b_rsp[%0d] got data=%h carry=%b expected data=%h carry=%b", j, d, cr, e.data, e.carry);
          end
          got++;
          @(posedge clk); #1;
        end
      end
    join
    checks++;
    if (got != 5) begin
      failures++;
      $display("FAIL b2b_count got %0d responses expected 5", got);
    end
    for (int i = 1; i < 5; i++) begin
      checks++;
      if (!ok_arr[i] || !ok_arr[i-1] || acc_arr[i] - acc_arr[i-1] != 3) begin
        failures++;
        $display("FAIL b2b_spacing[%0d] got %0d cycles expected 3", i, acc_arr[i] - acc_arr[i-1]);
      end
    end
    exp_q.delete();
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_ld    = 1'b0;
    cmd_op    = 3'b000;
    cmd_in    = 1'b0;
    cmd_imm   = 8'h00;
    cmd_ra    = 2'd0;
    cmd_rb    = 2'd0;
    cmd_rd    = 2'd0;
    rsp_ready = 1'b0;
    test_reset();
    test_add_sub();
    test_shifts();
    test_backpressure();
    test_reset_mid_issue();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Command-side driver for the team's 8-bit combinational ALU (ports a, b, ctrl_op, ctrl_in, out_signal, carry_bit).
- Accepts ALU or load-immediate commands over a valid/ready interface. Drives the ALU from a small internal register file, captures the result and carry back into that file, and returns each result on a valid/ready response channel.
- Sits between a host/control FSM and the ALU instance; strictly one command in flight.

Parameters:
- WIDTH, 8, data width; must match the ALU operand width.
- NREGS, 4, register-file depth (power of two); index width is log2(NREGS).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_ld  in  1  1 = load immediate, 0 = ALU operation.
- cmd_op  in  3  ALU operation code, passed through as ctrl_op.
- cmd_in  in  1  operand select for shift/rotate ops, passed through as ctrl_in.
- cmd_imm  in  WIDTH  immediate value for load.
- cmd_ra  in  log2(NREGS)  source register driven on ALU a.
- cmd_rb  in  log2(NREGS)  source register driven on ALU b.
- cmd_rd  in  log2(NREGS)  destination register.
- alu_a  out  WIDTH  to ALU a.
- alu_b  out  WIDTH  to ALU b.
- alu_op  out  3  to ALU ctrl_op.
- alu_ctrl_in  out  1  to ALU ctrl_in.
- alu_result  in  WIDTH  from ALU out_signal.
- alu_carry  in  1  from ALU carry_bit.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  WIDTH  value written to rd.
- rsp_carry  out  1  carry of that operation.
- busy  out  1  high in any state except IDLE.

Behaviour:
- States: IDLE, ISSUE, RESP.
- cmd_ready = (state==IDLE) and not rst. Accept = cmd_valid & cmd_ready.
- IDLE, accept with cmd_ld=1:
  - regs[rd] <= cmd_imm; rsp_data <= cmd_imm; rsp_carry <= 0; go to RESP.
  - ALU outputs unchanged.
- IDLE, accept with cmd_ld=0:
  - Register alu_a <= regs[ra], alu_b <= regs[rb], alu_op <= cmd_op, alu_ctrl_in <= cmd_in.
  - Latch rd; go to ISSUE.
- ISSUE (exactly one cycle; ALU is combinational and settles within it), at the end of the cycle:
  - regs[rd] <= alu_result; rsp_data <= alu_result.
  - rsp_carry <= alu_carry if alu_op==3'b000, else 0 (defensive mask).
  - Go to RESP.
- RESP:
  - rsp_valid=1; rsp_data and rsp_carry held stable until rsp_ready.
  - On rsp_valid & rsp_ready, go to IDLE.
- Latency (rsp_ready held high):
  - ALU op: rsp_valid asserts 2 cycles after the accept edge; next accept possible 3 cycles after the previous accept.
  - Load: rsp_valid asserts the cycle after accept; 2 cycles per load.
- alu_a, alu_b, alu_op and alu_ctrl_in hold their last values outside ISSUE. No glitching: all are registered.
- ra, rb and rd may alias; sources are read at the accept edge, so rd==ra uses the old value.
- Arithmetic is entirely inside the ALU; the sequencer performs no width extension. Results are truncated to WIDTH by the ALU.
- Reset (asserted at any time, including mid-ISSUE or mid-RESP):
  - Immediately: state=IDLE, all regs=0, alu_* =0, rsp_valid=0, rsp_data=0, rsp_carry=0, busy=0.
  - An in-flight command is discarded with no register write and no response.
- cmd_valid in a non-IDLE state is ignored (not accepted); the host holds it.
- rsp_ready while rsp_valid=0 has no effect.

Decomposition:
- Package alu_seq_pkg:
  - Opcode constants OP_ADD=000, OP_SUB=001, OP_AND=010, OP_OR=011, OP_ROL=100, OP_ROR=101, OP_SHL=110, OP_SHR=111.
  - CTRL_SEL_A=0, CTRL_SEL_B=1.
  - State enum (IDLE/ISSUE/RESP).
  - Default WIDTH/NREGS.
- One sub-module: alu_seq_regfile.
  - NREGS x WIDTH, two combinational read ports, one synchronous write port.
  - Async reset to zero.
- The bench instantiates alu_sequencer plus the real ALU, wired back-to-back.

Test Plan:
- Load R0=0xC8, R1=0x64; ADD rd=R2 ra=R0 rb=R1 -> rsp_data=0x2C, rsp_carry=1; rsp_valid 2 cycles after accept.
- SUB rd=R3 ra=R1 rb=R0 (0x64-0xC8) -> rsp_data=0x9C, rsp_carry=0; then ADD R3,R3,R3 -> 0x38 (aliasing uses old value 0x9C).
- Load R0=0x81; op 100 ctrl_in=0 -> 0x03; op 101 -> 0xC0; op 111 -> 0x40; op 110 -> 0x02; rsp_carry=0 for all four.
- rsp_ready held low 4 cycles in RESP -> rsp_valid, rsp_data and rsp_carry stable; cmd_ready=0; a cmd_valid pulse presented meanwhile is not consumed.
- Assert rst during ISSUE of ADD into R2 (R2 previously 0x55) -> no rsp_valid; R2 reads 0 afterwards; cmd_ready=1 the first cycle after rst deasserts.
- rsp_ready tied high, cmd_valid continuous with 5 ALU ops -> exactly one accept every 3 cycles; results in order.
